// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
// 2*WIDTH-bit dividend / WIDTH-bit divisor -> 2*WIDTH-bit quotient, WIDTH-bit remainder.
// Optional feature macro: DIV_ZERO_DETECT_EN. When it is defined, a zero divisor
// skips the iteration phase and raises o_div_zero. When it is undefined, a zero
// divisor runs all iterations and o_div_zero stays low.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [2*WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0]   o_remainder,
  output logic               o_div_zero
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Working registers: the dividend register doubles as the quotient shifter.
  logic [WIDTH:0]   r_prem;
  logic [DW-1:0]    r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [CW-1:0]    r_cnt;

  // Registered outputs.
  logic             r_busy;
  logic             r_done;
  logic [DW-1:0]    r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;

  // One restoring step.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH:0]   w_prem_nxt;
  logic [DW-1:0]    w_dvd_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_zero_skip;

`ifdef DIV_ZERO_DETECT_EN
  assign w_zero_skip = (i_divisor == {WIDTH{1'b0}});
`else
  assign w_zero_skip = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_ITER);

  // A zero divisor makes every trial subtract succeed. The quotient then fills
  // with ones, and the remainder ends up holding the low dividend bits.
  // Shift the partial remainder left, then trial-subtract the divisor.
  always_comb begin
    w_shift    = {r_prem[WIDTH-1:0], r_dvd[DW-1]};
    w_ge       = (w_shift >= {1'b0, r_dsr});
    w_prem_nxt = w_shift;
    if (w_ge) begin
      w_prem_nxt = w_shift - {1'b0, r_dsr};
    end else begin
      w_prem_nxt = w_shift;
    end
    w_dvd_nxt  = {r_dvd[DW-2:0], w_ge};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_zero_skip) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on accepted start, then one iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prem <= {(WIDTH+1){1'b0}};
      r_dvd  <= {DW{1'b0}};
      r_dsr  <= {WIDTH{1'b0}};
      r_cnt  <= {CW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_prem <= {(WIDTH+1){1'b0}};
            r_dvd  <= i_dividend;
            r_dsr  <= i_divisor;
            r_cnt  <= {CW{1'b0}};
          end else begin
            r_cnt  <= r_cnt;
          end
        end
        S_RUN: begin
          r_prem <= w_prem_nxt;
          r_dvd  <= w_dvd_nxt;
          r_cnt  <= r_cnt + CW'(1'b1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Results are loaded only on the edge that enters DONE and held through IDLE.
  // done is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= {DW{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_div_zero  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= 1'b0;
      if (w_last) begin
        r_quotient  <= w_dvd_nxt;
        r_remainder <= w_prem_nxt[WIDTH-1:0];
        r_div_zero  <= 1'b0;
        r_done      <= 1'b1;
      end else if (w_accept && w_zero_skip) begin
        r_quotient  <= {DW{1'b1}};
        r_remainder <= i_dividend[WIDTH-1:0];
        r_div_zero  <= 1'b1;
        r_done      <= 1'b1;
      end else begin
        r_quotient  <= r_quotient;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
`ifdef DIV_ZERO_DETECT_EN
  assign o_div_zero  = r_div_zero;
`else
  assign o_div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): the driver pushes expectations,
// and the monitor pops and compares on every done pulse.
module tb_seq_divider;

  localparam int W  = 4;
  localparam int DW = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_dividend = 8'd0;
  logic [W-1:0]  i_divisor = 4'd0;
  logic          o_busy;
  logic          o_done;
  logic [DW-1:0] o_quotient;
  logic [W-1:0]  o_remainder;
  logic          o_div_zero;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_done = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_div_zero  (o_div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t ref_div(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q  = 8'hFF;
      e.r  = a[3:0];
      e.dz = ZD;
    end else begin
      e.q  = a / {4'd0, b};
      e.r  = 4'(a % {4'd0, b});
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare against the scoreboard on each done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_done) begin
        check("done_pulse_prev", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done with q=%0d r=%0d, expected no done", o_quotient, o_remainder);
        end else begin
          e = sb.pop_front();
          check("quotient",  32'(o_quotient),  32'(e.q));
          check("remainder", 32'(o_remainder), 32'(e.r));
          check("div_zero",  32'(o_div_zero),  32'(e.dz));
        end
      end
      prev_done = o_done;
    end
  end

  // Waits a bounded time for done and returns the number of edges after acceptance.
  task automatic wait_done(output int cnt, output bit got);
    cnt = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (o_done) begin
        got = 1'b1;
      end else begin
        @(posedge clk);
        cnt++;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected done");
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input exp_t e);
    int cnt;
    bit got;
    @(negedge clk);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_done(cnt, got);
    if (got) check("latency", 32'(cnt), (ZD && b == 4'd0) ? 32'd0 : 32'd8);
    @(posedge clk);
    #1 check("busy_idle", 32'(o_busy), 32'd0);
    check("hold_q", 32'(o_quotient), 32'(e.q));
  endtask

  // Watchdog against a hung run.
  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin : driver
    int  cnt;
    bit  got;
    #12;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_q",    32'(o_quotient), 32'd0);
    check("rst_r",    32'(o_remainder), 32'd0);
    check("rst_dz",   32'(o_div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    run_op(8'd200, 4'd12, '{q: 8'd16,  r: 4'd8,  dz: 1'b0});
    run_op(8'd255, 4'd1,  '{q: 8'd255, r: 4'd0,  dz: 1'b0});
    run_op(8'd7,   4'd15, '{q: 8'd0,   r: 4'd7,  dz: 1'b0});
    run_op(8'hA5,  4'd0,  '{q: 8'hFF,  r: 4'h5,  dz: ZD});
    run_op(8'd0,   4'd5,  '{q: 8'd0,   r: 4'd0,  dz: 1'b0});
    run_op(8'd255, 4'd15, '{q: 8'd17,  r: 4'd0,  dz: 1'b0});
    run_op(8'd100, 4'd7,  '{q: 8'd14,  r: 4'd2,  dz: 1'b0});

    // Start held through RUN with new operands: must be ignored.
    @(negedge clk);
    i_dividend = 8'd200;
    i_divisor  = 4'd12;
    i_start    = 1'b1;
    sb.push_back('{q: 8'd16, r: 4'd8, dz: 1'b0});
    @(posedge clk);
    #1 i_dividend = 8'd7;
    i_divisor = 4'd15;
    repeat (3) @(posedge clk);
    #1 check("busy_run", 32'(o_busy), 32'd1);
    i_start = 1'b0;
    wait_done(cnt, got);
    @(posedge clk);
    run_op(8'd7, 4'd15, '{q: 8'd0, r: 4'd7, dz: 1'b0});

    // Reset in the middle of an iteration run: abort with no done pulse.
    run_op(8'd200, 4'd12, '{q: 8'd16, r: 4'd8, dz: 1'b0});
    @(negedge clk);
    i_dividend = 8'd255;
    i_divisor  = 4'd1;
    i_start    = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_q",    32'(o_quotient), 32'd0);
    check("abort_r",    32'(o_remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd200, 4'd12, '{q: 8'd16, r: 4'd8, dz: 1'b0});

    // Full operand sweep against the behavioural / and %.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(8'(a), 4'(b), ref_div(8'(a), 4'(b)));
      end
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
